// File: rtl/avm_wide_slave_adapter.sv
// Avalon-MM responder that gathers RATIO narrow write beats into one wide write and
// scatters each returned wide read word into RATIO narrow read beats, LSB slice first.

module avm_wide_slave_adapter_slot #(
   parameter int MWIDTH_BYTES = 32
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      load,
   input  logic [8*MWIDTH_BYTES-1:0] d,
   input  logic [MWIDTH_BYTES-1:0]   be,
   output logic [8*MWIDTH_BYTES-1:0] q,
   output logic [MWIDTH_BYTES-1:0]   q_be
);
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         q    <= '0;
         q_be <= '0;
      end else if (load) begin
         q    <= d;
         q_be <= be;
      end
endmodule

module avm_wide_slave_adapter #(
   parameter int AWIDTH           = 32,
   parameter int WIDTH_BYTES      = 64,
   parameter int MWIDTH_BYTES     = 32,
   parameter int BURSTCOUNT_WIDTH = 6,
   parameter int RD_FIFO_DEPTH    = 16
) (
   input  logic                                                      clock,
   input  logic                                                      resetn,
   input  logic [AWIDTH-1:0]                                         s_address,
   input  logic                                                      s_read,
   input  logic                                                      s_write,
   input  logic [8*MWIDTH_BYTES-1:0]                                 s_writedata,
   input  logic [MWIDTH_BYTES-1:0]                                   s_byteenable,
   input  logic [BURSTCOUNT_WIDTH-1:0]                               s_burstcount,
   output logic                                                      s_waitrequest,
   output logic [8*MWIDTH_BYTES-1:0]                                 s_readdata,
   output logic                                                      s_readdatavalid,
   output logic                                                      s_writeack,
   output logic [AWIDTH-1:0]                                         m_address,
   output logic                                                      m_read,
   output logic                                                      m_write,
   output logic [8*WIDTH_BYTES-1:0]                                  m_writedata,
   output logic [WIDTH_BYTES-1:0]                                    m_byteenable,
   output logic [BURSTCOUNT_WIDTH-$clog2(WIDTH_BYTES/MWIDTH_BYTES)-1:0] m_burstcount,
   input  logic                                                      m_waitrequest,
   input  logic [8*WIDTH_BYTES-1:0]                                  m_readdata,
   input  logic                                                      m_readdatavalid,
   input  logic                                                      m_writeack
);
   localparam int RATIO = WIDTH_BYTES / MWIDTH_BYTES;
   localparam int IDXW  = $clog2(RATIO);
   localparam int MBCW  = BURSTCOUNT_WIDTH - IDXW;
   localparam int MW    = 8 * MWIDTH_BYTES;
   localparam int PW    = $clog2(RD_FIFO_DEPTH);
   localparam int CRW   = PW + 1;
   localparam int SUMW  = ((MBCW > CRW) ? MBCW : CRW) + 1;
   localparam int ACKW  = $clog2(2 * RD_FIFO_DEPTH * RATIO + 1);
   localparam int ALW   = $clog2(WIDTH_BYTES);

   typedef enum logic [1:0] {IDLE, WR_COLLECT, WR_ISSUE, RD_ISSUE} state_t;
   state_t state, state_nx;

   logic                                        ready_q;
   logic [IDXW-1:0]                             idx, cur_idx, uidx;
   logic [MBCW-1:0]                             wleft, s_wbc;
   logic [CRW-1:0]                              rd_credit;
   logic [ACKW-1:0]                             ack_pending;
   logic [RD_FIFO_DEPTH-1:0][8*WIDTH_BYTES-1:0] fifo;
   logic [PW:0]                                 wr_ptr, rd_ptr;
   logic [RATIO-1:0][MW-1:0]                    slot_d, head;
   logic [RATIO-1:0][MWIDTH_BYTES-1:0]          slot_be;
   logic                                        rd_fits, wr_beat, wr_first, rd_acc, wr_done;
   logic                                        ubeat, upop;

   assign s_wbc    = s_burstcount[BURSTCOUNT_WIDTH-1:IDXW];
   assign rd_fits  = (SUMW'(rd_credit) + SUMW'(s_wbc)) <= SUMW'(RD_FIFO_DEPTH);
   assign wr_beat  = s_write && !s_waitrequest && (state == IDLE || state == WR_COLLECT);
   assign wr_first = wr_beat && (state == IDLE);
   assign rd_acc   = (state == IDLE) && s_read && !s_write && !s_waitrequest;
   assign wr_done  = (state == WR_ISSUE) && !m_waitrequest;
   assign cur_idx  = (state == IDLE) ? '0 : idx;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) state <= IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (wr_beat) state_nx = WR_COLLECT;
                     else if (rd_acc) state_nx = RD_ISSUE;
         WR_COLLECT: if (wr_beat && idx == IDXW'(RATIO-1)) state_nx = WR_ISSUE;
         WR_ISSUE:   if (!m_waitrequest) state_nx = (wleft == MBCW'(1)) ? IDLE : WR_COLLECT;
         RD_ISSUE:   if (!m_waitrequest) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // ready_q keeps the slave stalled through reset and the first cycle after it
   always_comb begin
      s_waitrequest = 1'b1;
      m_write       = 1'b0;
      m_read        = 1'b0;
      case (state)
         IDLE:       s_waitrequest = !ready_q || (s_read && !s_write && !rd_fits);
         WR_COLLECT: s_waitrequest = 1'b0;
         WR_ISSUE:   m_write = 1'b1;
         RD_ISSUE:   m_read = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         ready_q      <= 1'b0;
         idx          <= '0;
         wleft        <= '0;
         m_address    <= '0;
         m_burstcount <= '0;
      end else begin
         ready_q <= 1'b1;
         if (wr_beat) idx <= wr_first ? IDXW'(1) : idx + 1'b1;
         if (wr_first || rd_acc) begin
            m_address    <= s_address;
            m_burstcount <= s_wbc;
         end
         if (wr_first)     wleft <= s_wbc;
         else if (wr_done) wleft <= wleft - 1'b1;
      end

   for (genvar r = 0; r < RATIO; r++) begin : g_slot
      avm_wide_slave_adapter_slot #(.MWIDTH_BYTES(MWIDTH_BYTES)) u_slot (
         .clock  (clock),
         .resetn (resetn),
         .load   (wr_beat && cur_idx == IDXW'(r)),
         .d      (s_writedata),
         .be     (s_byteenable),
         .q      (slot_d[r]),
         .q_be   (slot_be[r])
      );
   end

   assign m_writedata  = slot_d;
   assign m_byteenable = slot_be;

   // read return path: wide words queue up, unloader walks the slices of the head word
   assign head            = fifo[rd_ptr[PW-1:0]];
   assign ubeat           = (wr_ptr != rd_ptr);
   assign upop            = ubeat && (uidx == IDXW'(RATIO-1));
   assign s_readdatavalid = ubeat;
   assign s_readdata      = ubeat ? head[uidx] : '0;
   assign s_writeack      = (ack_pending != '0);

   always_ff @(posedge clock)
      if (m_readdatavalid) fifo[wr_ptr[PW-1:0]] <= m_readdata;

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         uidx        <= '0;
         rd_credit   <= '0;
         ack_pending <= '0;
      end else begin
         if (m_readdatavalid) wr_ptr <= wr_ptr + 1'b1;
         if (ubeat)           uidx   <= uidx + 1'b1;
         if (upop)            rd_ptr <= rd_ptr + 1'b1;
         rd_credit   <= rd_credit + (rd_acc ? CRW'(s_wbc) : CRW'(0)) - CRW'(upop);
         ack_pending <= ack_pending + (m_writeack ? ACKW'(RATIO) : ACKW'(0)) - ACKW'(s_writeack);
      end

`ifndef SYNTHESIS
   a_legal_cmd: assert property (@(posedge clock) disable iff (!resetn)
      (wr_first || rd_acc) |-> (s_address[ALW-1:0] == '0 && s_burstcount[IDXW-1:0] == '0));
`endif
endmodule
